// File: rtl/pm_pkg.sv
// pm_pkg: shared types, default parameter values and helpers for the
// rate-paced scheduler (pm_scheduler / pm_flow_pacer).
package pm_pkg;

  localparam int unsigned PM_NUM_FLOWS    = 4;
  localparam int unsigned PM_PERIOD_WIDTH = 16;
  localparam int unsigned PM_FRAC_WIDTH   = 8;
  localparam int unsigned PM_MAX_CREDIT   = 4;

  typedef logic [$clog2(PM_NUM_FLOWS)-1:0]    flow_idx_t;
  typedef logic [$clog2(PM_MAX_CREDIT+1)-1:0] credit_t;

  // A zero period is treated as one cycle.
  function automatic logic [31:0] pm_clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/pm_flow_pacer.sv
// pm_flow_pacer: per-flow fractional-period pacing timer and credit counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_we            write strobe for this flow (enable, period, fraction)
//   cfg_en/period/frac  configuration values
//   dec               a grant for this flow was accepted; consume one credit
//   has_credit        credit > 0
//   ovf               one-cycle pulse: a tick was lost to credit saturation
module pm_flow_pacer
  import pm_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = PM_PERIOD_WIDTH,
  parameter int unsigned FRAC_WIDTH   = PM_FRAC_WIDTH,
  parameter int unsigned MAX_CREDIT   = PM_MAX_CREDIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic                    cfg_en,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic [FRAC_WIDTH-1:0]   cfg_frac,
  input  logic                    dec,
  output logic                    has_credit,
  output logic                    ovf
);

  localparam int unsigned CW = $clog2(MAX_CREDIT + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(MAX_CREDIT);

  logic                    en;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [FRAC_WIDTH-1:0]   frac;
  logic [FRAC_WIDTH-1:0]   acc;
  logic [CW-1:0]           credit;

  logic [PERIOD_WIDTH-1:0] reload;
  logic [PERIOD_WIDTH-1:0] cfg_reload;
  logic [FRAC_WIDTH:0]     acc_sum;
  logic [CW-1:0]           credit_dec;
  logic                    tick;

  always_comb begin
    reload     = PERIOD_WIDTH'(pm_clamp_period(32'(period)) - 32'd1);
    cfg_reload = PERIOD_WIDTH'(pm_clamp_period(32'(cfg_period)) - 32'd1);
    acc_sum    = {1'b0, acc} + {1'b0, frac};
    // Decrement first so a same-cycle tick and handshake cancel out and the
    // saturation test sees the post-decrement value.
    credit_dec = (dec && credit != '0) ? credit - CW'(1) : credit;
    tick       = en && (cnt == '0);
  end

  assign has_credit = (credit != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      period <= '0;
      frac   <= '0;
      cnt    <= '0;
      acc    <= '0;
      credit <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (cfg_we) begin
        // A config write overrides any tick due this cycle.
        en     <= cfg_en;
        period <= cfg_period;
        frac   <= cfg_frac;
        cnt    <= cfg_reload;
        acc    <= '0;
        credit <= cfg_en ? credit_dec : '0;
      end else if (tick) begin
        acc <= acc_sum[FRAC_WIDTH-1:0];
        cnt <= reload + PERIOD_WIDTH'(acc_sum[FRAC_WIDTH]);
        if (credit_dec == CRED_MAX) begin
          credit <= credit_dec;
          ovf    <= 1'b1;
        end else begin
          credit <= credit_dec + CW'(1);
        end
      end else begin
        if (en) cnt <= cnt - PERIOD_WIDTH'(1);
        credit <= credit_dec;
      end
    end
  end

endmodule

// File: rtl/pm_scheduler.sv
// pm_scheduler: shares one frame generator between NUM_FLOWS rate-paced flows.
// Each flow earns credits from its own pacer; a round-robin arbiter turns
// credits into grants delivered over a valid/ready handshake.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_we, cfg_flow, cfg_en,
//   cfg_period, cfg_frac            per-flow configuration write
//   gnt_valid, gnt_flow, gnt_ready  grant handshake to the generator
//   credit_ovf                      per-flow pulse on a lost tick
module pm_scheduler
  import pm_pkg::*;
#(
  parameter int unsigned NUM_FLOWS    = PM_NUM_FLOWS,
  parameter int unsigned PERIOD_WIDTH = PM_PERIOD_WIDTH,
  parameter int unsigned FRAC_WIDTH   = PM_FRAC_WIDTH,
  parameter int unsigned MAX_CREDIT   = PM_MAX_CREDIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_FLOWS)-1:0] cfg_flow,
  input  logic                         cfg_en,
  input  logic [PERIOD_WIDTH-1:0]      cfg_period,
  input  logic [FRAC_WIDTH-1:0]        cfg_frac,
  output logic                         gnt_valid,
  output logic [$clog2(NUM_FLOWS)-1:0] gnt_flow,
  input  logic                         gnt_ready,
  output logic [NUM_FLOWS-1:0]         credit_ovf
);

  localparam int unsigned IW = $clog2(NUM_FLOWS);

  logic [NUM_FLOWS-1:0] has_credit;
  logic [NUM_FLOWS-1:0] flow_we;
  logic [NUM_FLOWS-1:0] dec;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        sel;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        next_ptr;
  logic                 found;
  logic                 hs;

  assign hs = gnt_valid && gnt_ready;

  for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_flow
    assign flow_we[g] = cfg_we && (cfg_flow == IW'(g));
    assign dec[g]     = hs && (gnt_flow == IW'(g));

    pm_flow_pacer #(
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .FRAC_WIDTH   (FRAC_WIDTH),
      .MAX_CREDIT   (MAX_CREDIT)
    ) u_pacer (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (flow_we[g]),
      .cfg_en     (cfg_en),
      .cfg_period (cfg_period),
      .cfg_frac   (cfg_frac),
      .dec        (dec[g]),
      .has_credit (has_credit[g]),
      .ovf        (credit_ovf[g])
    );
  end

  // First flow with credit, searching upward from rr_ptr with wrap-around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
      idx = IW'((32'(rr_ptr) + i) % NUM_FLOWS);
      if (!found && has_credit[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    next_ptr = (gnt_flow == IW'(NUM_FLOWS - 1)) ? '0 : gnt_flow + IW'(1);
  end

  // A pending grant is held regardless of later credit or config changes;
  // after a handshake valid stays low for one cycle so the arbiter sees
  // the decremented credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_valid <= 1'b0;
      gnt_flow  <= '0;
      rr_ptr    <= '0;
    end else if (gnt_valid) begin
      if (gnt_ready) begin
        gnt_valid <= 1'b0;
        rr_ptr    <= next_ptr;
      end
    end else if (found) begin
      gnt_valid <= 1'b1;
      gnt_flow  <= sel;
    end
  end

endmodule

// File: tb/tb_pm_scheduler.sv
// tb_pm_scheduler: directed scenarios plus randomized traffic for
// pm_scheduler, checked every cycle against a behavioural model that tracks
// absolute tick times and per-flow credit counts.
module tb_pm_scheduler;

  localparam int NF = 4;
  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_flow;
  logic        cfg_en;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_frac;
  logic        gnt_valid;
  logic [1:0]  gnt_flow;
  logic        gnt_ready;
  logic [3:0]  credit_ovf;

  always #5 clk = ~clk;

  pm_scheduler #(
    .NUM_FLOWS    (NF),
    .PERIOD_WIDTH (16),
    .FRAC_WIDTH   (8),
    .MAX_CREDIT   (MC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_flow   (cfg_flow),
    .cfg_en     (cfg_en),
    .cfg_period (cfg_period),
    .cfg_frac   (cfg_frac),
    .gnt_valid  (gnt_valid),
    .gnt_flow   (gnt_flow),
    .gnt_ready  (gnt_ready),
    .credit_ovf (credit_ovf)
  );

  int errors = 0;
  int checks = 0;

  // Model: tick times are kept as absolute edge numbers.
  int         m_en[NF], m_p[NF], m_f[NF], m_next[NF], m_acc[NF], m_cred[NF];
  int         m_gv, m_gf, m_rr;
  logic [3:0] m_ovf;
  int         edge_no;

  int         hs_cnt;
  logic [3:0] ovf_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_en[i] = 0; m_p[i] = 0; m_f[i] = 0; m_next[i] = 0; m_acc[i] = 0; m_cred[i] = 0;
    end
    m_gv = 0; m_gf = 0; m_rr = 0; m_ovf = '0; edge_no = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int new_cred[NF];
    int pc, s, c;
    int hs;
    hs = (m_gv != 0) && gnt_ready;
    m_ovf = '0;
    for (int i = 0; i < NF; i++) begin
      c = m_cred[i];
      if (hs != 0 && m_gf == i && c > 0) c--;
      if (cfg_we && int'(cfg_flow) == i) begin
        m_en[i]   = int'(cfg_en);
        m_p[i]    = int'(cfg_period);
        m_f[i]    = int'(cfg_frac);
        m_acc[i]  = 0;
        pc        = (m_p[i] == 0) ? 1 : m_p[i];
        m_next[i] = edge_no + pc;
        if (!cfg_en) c = 0;
      end else if (m_en[i] != 0 && edge_no == m_next[i]) begin
        pc        = (m_p[i] == 0) ? 1 : m_p[i];
        s         = m_acc[i] + m_f[i];
        m_acc[i]  = s % 256;
        m_next[i] = edge_no + pc + s / 256;
        if (c == MC) m_ovf[i] = 1'b1;
        else c++;
      end
      new_cred[i] = c;
    end
    // Arbiter decides on the credits visible before this edge.
    if (m_gv != 0) begin
      if (gnt_ready) begin
        m_gv = 0;
        m_rr = (m_gf + 1) % NF;
      end
    end else begin
      for (int k = 0; k < NF; k++) begin
        if (m_gv == 0 && m_cred[(m_rr + k) % NF] > 0) begin
          m_gv = 1;
          m_gf = (m_rr + k) % NF;
        end
      end
    end
    for (int i = 0; i < NF; i++) m_cred[i] = new_cred[i];
    edge_no++;
  endtask

  task automatic check_outputs();
    check("gnt_valid", 32'(gnt_valid), 32'(m_gv));
    check("gnt_flow", 32'(gnt_flow), 32'(m_gf));
    check("credit_ovf", 32'(credit_ovf), 32'(m_ovf));
    ovf_seen = ovf_seen | credit_ovf;
  endtask

  task automatic step(input logic we, input logic [1:0] flow, input logic en,
                      input logic [15:0] period, input logic [7:0] frac,
                      input logic ready);
    cfg_we = we; cfg_flow = flow; cfg_en = en;
    cfg_period = period; cfg_frac = frac; gnt_ready = ready;
    if (gnt_valid && ready) hs_cnt++;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 16'd0, 8'd0, ready);
  endtask

  task automatic do_reset();
    cfg_we = 1'b0; cfg_flow = '0; cfg_en = 1'b0; cfg_period = '0; cfg_frac = '0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic disable_all();
    for (int i = 0; i < NF; i++) step(1'b1, 2'(i), 1'b0, 16'd0, 8'd0, 1'b1);
    idle(4, 1'b1);
  endtask

  initial begin
    gnt_ready = 1'b0;
    hs_cnt = 0;
    ovf_seen = '0;
    @(negedge clk);
    do_reset();
    check("reset_valid", 32'(gnt_valid), 32'd0);
    check("reset_ovf", 32'(credit_ovf), 32'd0);
    idle(3, 1'b1);

    // Single flow, integer period 4: one grant every 4 cycles.
    step(1'b1, 2'd0, 1'b1, 16'd4, 8'd0, 1'b1);
    idle(8, 1'b1);
    hs_cnt = 0; ovf_seen = '0;
    idle(40, 1'b1);
    check("p4_grants", 32'(hs_cnt), 32'd10);
    check("p4_no_ovf", 32'(ovf_seen), 32'd0);
    disable_all();

    // Fractional period 4.5: 20 grants in 90 cycles, +/-1.
    step(1'b1, 2'd1, 1'b1, 16'd4, 8'd128, 1'b1);
    idle(8, 1'b1);
    hs_cnt = 0;
    idle(90, 1'b1);
    check("frac_grants_in_range", 32'(hs_cnt >= 19 && hs_cnt <= 21), 32'd1);
    disable_all();

    // All flows at P=1: round-robin order, every flow overflows.
    for (int i = 0; i < NF; i++) step(1'b1, 2'(i), 1'b1, 16'd1, 8'd0, 1'b1);
    idle(8, 1'b1);
    ovf_seen = '0; hs_cnt = 0;
    idle(40, 1'b1);
    check("rr_all_ovf", 32'(ovf_seen), 32'hF);
    check("rr_grants", 32'(hs_cnt), 32'd20);
    disable_all();

    // Backpressure on flow 2: grant held, credit saturates, overflow pulses.
    step(1'b1, 2'd2, 1'b1, 16'd2, 8'd0, 1'b0);
    ovf_seen = '0;
    idle(20, 1'b0);
    check("bp_ovf2", 32'(ovf_seen), 32'h4);
    idle(30, 1'b1);
    disable_all();

    // Disable flow 3 while its grant is pending.
    step(1'b1, 2'd3, 1'b1, 16'd3, 8'd0, 1'b0);
    idle(6, 1'b0);
    step(1'b1, 2'd3, 1'b0, 16'd0, 8'd0, 1'b0);
    idle(3, 1'b0);
    hs_cnt = 0;
    idle(10, 1'b1);
    check("dis_one_hs", 32'(hs_cnt), 32'd1);

    // P=0 behaves as P=1.
    step(1'b1, 2'd3, 1'b1, 16'd0, 8'd0, 1'b1);
    idle(6, 1'b1);
    hs_cnt = 0;
    idle(20, 1'b1);
    check("p0_grants", 32'(hs_cnt), 32'd10);
    disable_all();

    // Reset with credits pending: no grants afterwards.
    step(1'b1, 2'd0, 1'b1, 16'd1, 8'd0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 16'd1, 8'd0, 1'b0);
    idle(10, 1'b0);
    do_reset();
    check("rst_mid_valid", 32'(gnt_valid), 32'd0);
    hs_cnt = 0;
    idle(10, 1'b1);
    check("rst_no_grants", 32'(hs_cnt), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        step(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             16'($urandom_range(0, 6)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      end else begin
        idle(1, 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pm_scheduler.md
# pm_scheduler

Rate-paced scheduler that shares one frame generator between `NUM_FLOWS` flows, each with its own target bandwidth. Each flow runs a fractional-period pacing timer that earns transmit credits. A round-robin arbiter turns those credits into grants, delivered to the shared generator over a valid/ready handshake. It sits between the runtime configuration registers and the traffic generator datapath, replacing fixed per-generator pacing pulses.

## Interface
- `NUM_FLOWS`, 4: number of paced flows; must be at least 2.
- `PERIOD_WIDTH`, 16: width of the integer frame period, in clock cycles.
- `FRAC_WIDTH`, 8: width of the fractional period; the fraction's unit is 1/2^FRAC_WIDTH cycle.
- `MAX_CREDIT`, 4: credit saturation level per flow; must be at least 1.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `cfg_we`, in, 1: configuration write strobe.
- `cfg_flow`, in, `$clog2(NUM_FLOWS)`: index of the flow being written.
- `cfg_en`, in, 1: flow enable.
- `cfg_period`, in, `PERIOD_WIDTH`: integer period P.
- `cfg_frac`, in, `FRAC_WIDTH`: fractional period F.
- `gnt_valid`, out, 1: a grant is pending.
- `gnt_flow`, out, `$clog2(NUM_FLOWS)`: flow index of the pending grant.
- `gnt_ready`, in, 1: the generator accepts the grant (one frame).
- `credit_ovf`, out, `NUM_FLOWS`: one-cycle pulse per flow; a tick was lost because credit was saturated.

## Operation
- **Per-flow state:** enable, P, F, down-counter `cnt`, fraction accumulator `acc` (`FRAC_WIDTH` bits), credit (0..`MAX_CREDIT`).
- **Config write** (`cfg_we`=1):
  - P, F and enable for `cfg_flow` are registered.
  - `cnt` is set to `max(P,1)-1` and `acc` to 0.
  - Credit is kept if `cfg_en`=1 and cleared if `cfg_en`=0.
  - P=0 is treated as P=1.
- **Tick:** occurs when the flow is enabled and `cnt`==0.
  - `{carry, acc_next} = acc + F`.
  - `cnt` reloads with `max(P,1)-1+carry`.
  - Credit increments; at `MAX_CREDIT` it stays, and `credit_ovf[i]` pulses.
  - Average period is P + F/2^FRAC_WIDTH cycles.
- **Disabled flow:** `cnt` and `acc` hold; no ticks are generated.
- **Arbiter:**
  - When `gnt_valid`=0, select the first flow with credit>0, searching from `rr_ptr` upward with wrap-around.
  - Register `gnt_valid`=1 and `gnt_flow` on the next edge.
- **Handshake:** a handshake occurs when `gnt_valid` and `gnt_ready` are both 1.
  - The granted flow's credit decrements, saturating at 0.
  - `rr_ptr` becomes `gnt_flow+1` mod `NUM_FLOWS`.
  - `gnt_valid` drops for at least one cycle; there are no back-to-back grants.
- **Grant stability:** while `gnt_valid`=1 and `gnt_ready`=0, `gnt_flow` is stable and `gnt_valid` never drops. This holds even if the granted flow is disabled or reconfigured.
- **Same-cycle tick and handshake on one flow:** net credit is unchanged. The overflow check uses the post-decrement value, so no `credit_ovf` pulse occurs.
- **Same-cycle config write and tick on one flow:** the config write wins, and the tick is discarded.

## Timing
- **Reset values:**
  - Outputs: `gnt_valid`=0, `gnt_flow`=0, `credit_ovf`=0.
  - Per-flow state: all flows disabled; P, F, `cnt`, `acc` and credit all 0.
  - Arbiter: `rr_ptr`=0.
- **Reset mid-handshake:** the pending grant is abandoned with no handshake.
- **Enable to first tick:** a config write at edge 0 produces the first tick in the cycle where `cnt`==0, i.e. edge `max(P,1)-1`.
- **Tick to credit:** credit is visible at the next edge.
- **Credit to grant:** `gnt_valid` rises one edge after credit becomes visible, when the arbiter is idle.
- **Minimum spacing:** two cycles between accepted grants.
- **Peak acceptance rate:** one grant per 2 cycles; aggregate configured rates above this accumulate credit, then overflow.

## Structure
- **Package `pm_pkg`:**
  - `flow_idx_t` (`$clog2(NUM_FLOWS)` bits) and `credit_t` (`$clog2(MAX_CREDIT+1)` bits).
  - Function `pm_clamp_period` (maps 0 to 1).
  - Default parameter constants.
- **Sub-module `pm_flow_pacer`:** one instance per flow.
  - Holds the config registers, `cnt`, `acc` and credit.
  - Inputs: config write, decrement strobe.
  - Outputs: `has_credit`, `ovf`.
- **Top level:** instances via generate, plus the round-robin arbiter and grant register.

## Test plan
- **Single flow, integer period:** flow 0 with P=4, F=0, `gnt_ready`=1 -> grants for flow 0 exactly every 4 cycles; `credit_ovf`=0.
- **Fractional period:** flow 1 with P=4, F=128 (`FRAC_WIDTH`=8) -> periods alternate 4,5; 20 grants in 90 cycles ±1.
- **Round-robin fairness:** all 4 flows with P=1 -> grants in order 0,1,2,3,0,… every 2 cycles; every flow reports `credit_ovf` pulses.
- **Backpressure:** flow 2 with P=2, `gnt_ready`=0 for 20 cycles.
  - While stalled: `gnt_valid`/`gnt_flow`=2 are stable, credit saturates at 4, and `credit_ovf` pulses start once credit reaches 4.
  - After release: exactly 4 handshakes, then pacing resumes.
- **Disable/reconfigure during a pending grant:** disable flow 3 while its grant is pending -> the grant holds until the handshake, credit ends at 0, and no further grants occur. Writing P=0 behaves as P=1.
- **Reset mid-run:** assert `rst` with credits pending -> next cycle `gnt_valid`=0, all credits 0, and no grants until a config write.
